// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and valid/ready push side; frames go out LSB first, back to back.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (sense chosen by PARITY_ODD).
module uart_tx_fifo #(
    parameter int CLK_DIV    = 234,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);

    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_tx_fifo: illegal parameter value");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP  = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BAUD_W-1:0]    r_baud;
    logic [3:0]           r_bitcnt;
    logic                 r_tx;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_stop_done;
    logic                 w_shift_en;
    logic [DATA_BITS-1:0] w_head;

    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign s_ready     = !w_full && !rst;
    assign w_push      = s_valid && s_ready;
    assign w_bit_end   = (r_baud == BAUD_W'(CLK_DIV - 1));
    assign w_stop_done = (r_state == ST_STOP) && w_bit_end && (r_bitcnt == 4'(STOP_BITS));
    // A word leaves the FIFO either from idle or at the very end of the previous stop period.
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_stop_done);
    assign w_shift_en  = w_bit_end && ((r_state == ST_START) ||
                         ((r_state == ST_DATA) && (r_bitcnt < 4'(DATA_BITS))));
    assign w_head      = r_mem[r_rptr];

    assign tx         = r_tx;
    assign busy       = (r_state != ST_IDLE);
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
            r_parity <= (^w_head) ^ 1'(PARITY_ODD);
`endif
        end else if (w_shift_en) begin
            r_shift <= r_shift >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_tx     <= 1'b1;
            r_baud   <= '0;
            r_bitcnt <= '0;
        end else begin
            r_baud <= (r_state == ST_IDLE || w_bit_end) ? '0 : r_baud + BAUD_W'(1);
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx     <= r_shift[0];
                        r_bitcnt <= 4'd1;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bitcnt < 4'(DATA_BITS)) begin
                            r_tx     <= r_shift[0];
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx     <= 1'b1;
                            r_bitcnt <= 4'd1;
                            r_state  <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx     <= 1'b1;
                        r_bitcnt <= 4'd1;
                        r_state  <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_bitcnt < 4'(STOP_BITS)) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (!w_empty) begin
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed pushes, a per-instance frame monitor checking waveforms against a scoreboard.
// Parity instances are built only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int NI = 4;
`else
    localparam int NI = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data  [NI];
    logic       s_valid [NI];
    logic       s_ready [NI];
    logic       tx      [NI];
    logic       busy    [NI];
    logic [2:0] cnt     [NI];

    logic [7:0] sb [NI][$];
    int         nframes [NI];
    int         gap_log [NI][32];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_a (
        .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .tx(tx[0]), .busy(busy[0]), .fifo_count(cnt[0]));

    uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst(rst), .s_data(s_data[1][6:0]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .tx(tx[1]), .busy(busy[1]), .fifo_count(cnt[1]));

`ifdef UART_TX_PARITY_EN
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst(rst), .s_data(s_data[2]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .tx(tx[2]), .busy(busy[2]), .fifo_count(cnt[2]));

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .s_data(s_data[3]), .s_valid(s_valid[3]), .s_ready(s_ready[3]),
        .tx(tx[3]), .busy(busy[3]), .fifo_count(cnt[3]));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decodes every frame cycle by cycle and compares it with the next scoreboard entry.
    task automatic monitor(input int sel, input int div, input int nb, input int ns,
                           input int pe, input int po);
        int         gap = 0;
        int         total;
        int         bad;
        int         b;
        bit         abort;
        logic       eb;
        logic [7:0] exp;
        logic [7:0] dec;
        forever begin
            @(negedge clk);
            if (rst || tx[sel] !== 1'b0) begin
                gap++;
                continue;
            end
            exp = '0;
            if (sb[sel].size() == 0) chk($sformatf("unexpected_frame_%0d", sel), 0, 1);
            else exp = sb[sel].pop_front();
            gap_log[sel][nframes[sel] % 32] = gap;
            gap   = 0;
            total = (1 + nb + pe + ns) * div;
            bad   = 0;
            dec   = '0;
            abort = 1'b0;
            for (int k = 0; k < total; k++) begin
                if (k > 0) @(negedge clk);
                if (rst) begin
                    abort = 1'b1;
                    break;
                end
                b = k / div;
                if (b == 0)                        eb = 1'b0;
                else if (b <= nb)                  eb = exp[b-1];
                else if (pe != 0 && b == nb + 1)   eb = (^exp) ^ po[0];
                else                               eb = 1'b1;
                if (tx[sel] !== eb) bad++;
                if (b >= 1 && b <= nb && (k % div) == div / 2) dec[b-1] = tx[sel];
            end
            if (!abort) begin
                chk($sformatf("frame_wave_errs_%0d_%02h", sel, exp), bad, 0);
                chk($sformatf("frame_decoded_%0d", sel), dec, exp);
                nframes[sel]++;
            end
        end
    endtask

    initial monitor(0, 4, 8, 1, 0, 0);
    initial monitor(1, 3, 7, 2, 0, 0);
`ifdef UART_TX_PARITY_EN
    initial monitor(2, 4, 8, 1, 1, 0);
    initial monitor(3, 4, 8, 1, 1, 1);
`endif

    task automatic push(input int sel, input logic [7:0] d, output bit acc);
        s_data[sel]  = d;
        s_valid[sel] = 1'b1;
        acc = s_ready[sel];
        @(posedge clk);
        if (acc) sb[sel].push_back(d);
        @(negedge clk);
    endtask

    task automatic wait_frames(input int sel, input int n, input string tag);
        int c = 0;
        while (nframes[sel] < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk(tag, nframes[sel], n);
    endtask

    // Push one word at edge E into an idle instance; measure when tx first goes low and busy drops.
    task automatic timed_push(input int sel, input logic [7:0] d, input int exp_low,
                              input int exp_idle, input string tag);
        bit acc;
        int j;
        int first_low = -1;
        push(sel, d, acc);
        s_valid[sel] = 1'b0;
        chk({tag, "_accept"}, acc, 1);
        for (j = 1; j <= 100; j++) begin
            @(negedge clk);
            if (first_low < 0 && tx[sel] === 1'b0) first_low = j;
            if (first_low > 0 && busy[sel] === 1'b0) break;
        end
        chk({tag, "_first_low"}, first_low, exp_low);
        chk({tag, "_busy_drop"}, j, exp_idle);
    endtask

    initial begin
        bit         acc;
        int         base;
        int         c;
        logic [7:0] t3_words [4] = '{8'h22, 8'h33, 8'h44, 8'h55};

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = '0;
            nframes[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_tx", tx[0], 1);
        chk("rst_busy", busy[0], 0);
        chk("rst_count", cnt[0], 0);
        chk("rst_ready", s_ready[0], 0);
        chk("rst_tx_b", tx[1], 1);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", s_ready[0], 1);

        // single frame timing, 0x55
        timed_push(0, 8'h55, 1, 41, "t1");

        // three words on consecutive cycles
        repeat (5) @(negedge clk);
        base = nframes[0];
        push(0, 8'hA3, acc);
        chk("t2_cnt0", cnt[0], 1);
        push(0, 8'h0F, acc);
        chk("t2_cnt1", cnt[0], 1);
        push(0, 8'hFF, acc);
        chk("t2_cnt2", cnt[0], 2);
        s_valid[0] = 1'b0;
        wait_frames(0, base + 3, "t2_frames");
        chk("t2_gap_frame2", gap_log[0][(base + 1) % 32], 0);
        chk("t2_gap_frame3", gap_log[0][(base + 2) % 32], 0);
        chk("t2_drained", cnt[0], 0);

        // fill the FIFO behind a frame in flight
        repeat (5) @(negedge clk);
        base = nframes[0];
        push(0, 8'h11, acc);
        s_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            push(0, t3_words[i], acc);
            chk($sformatf("t3_accept_%0d", i), acc, 1);
        end
        chk("t3_ready_full", s_ready[0], 0);
        chk("t3_count_full", cnt[0], 4);
        s_data[0] = 8'h66;
        c = 0;
        while (s_ready[0] !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("t3_refused_at_pop", cnt[0], 3);
        push(0, 8'h66, acc);
        chk("t3_accept_5th", acc, 1);
        chk("t3_count_after_5th", cnt[0], 4);
        s_data[0] = 8'h77;
        c = 0;
        while (s_ready[0] !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        push(0, 8'h77, acc);
        chk("t3_accept_6th", acc, 1);
        s_valid[0] = 1'b0;
        wait_frames(0, base + 7, "t3_frames");

        // 7 data bits, 2 stop bits, CLK_DIV 3
        timed_push(1, 8'h41, 1, 31, "t5");
        base = nframes[1];
        push(1, 8'h2A, acc);
        push(1, 8'h15, acc);
        s_valid[1] = 1'b0;
        wait_frames(1, base + 2, "t5_frames");
        chk("t5_gap_frame2", gap_log[1][(base + 1) % 32], 0);

`ifdef UART_TX_PARITY_EN
        timed_push(2, 8'h07, 1, 45, "t4_even");
        timed_push(3, 8'h07, 1, 45, "t4_odd");
`endif

        // reset in the middle of the third data bit with two words queued
        repeat (5) @(negedge clk);
        base = nframes[0];
        push(0, 8'hC3, acc);
        push(0, 8'h5A, acc);
        push(0, 8'hE7, acc);
        s_valid[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("t6_busy_before", busy[0], 1);
        chk("t6_count_before", cnt[0], 2);
        rst = 1'b1;
        #1;
        chk("t6_tx_at_rst", tx[0], 1);
        chk("t6_busy_at_rst", busy[0], 0);
        chk("t6_count_at_rst", cnt[0], 0);
        chk("t6_ready_at_rst", s_ready[0], 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) sb[i].delete();
        repeat (80) @(negedge clk);
        chk("t6_no_frames", nframes[0], base);
        chk("t6_tx_idle", tx[0], 1);
        chk("t6_busy_idle", busy[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
